// File: rtl/fp32_pkg.sv
// Shared binary32 constants and the packed result type for the FP multiplier/adder datapaths.
package fp32_pkg;
  localparam int EXP_W   = 8;
  localparam int FRAC_W  = 23;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;
  localparam int E_W     = 11;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;
endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even of a normalised significand with guard and sticky bits.
module fp_round_rne
  import fp32_pkg::*;
(
  input  logic [FRAC_W:0]         m,
  input  logic                    g,
  input  logic                    s,
  input  logic signed [E_W-1:0]   e,
  output logic [FRAC_W-1:0]       fr,
  output logic signed [E_W-1:0]   e_out,
  output logic                    inexact
);
  logic            rnd;
  logic            carry;
  logic [FRAC_W:0] sum;

  always_comb begin
    rnd     = g & (s | m[0]);
    sum     = m + {{FRAC_W{1'b0}}, rnd};
    // Carry out of the fraction field flips the hidden-bit position of the sum.
    carry   = sum[FRAC_W] ^ m[FRAC_W];
    fr      = sum[FRAC_W-1:0];
    e_out   = e + E_W'(carry);
    inexact = g | s;
  end
endmodule

// File: rtl/fp_mult_norm_round.sv
// Post-multiply normalise / round / pack stage: two-entry valid/ready pipeline producing binary32.
module fp_mult_norm_round
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [9:0]  in_exp,
  input  logic [47:0] in_mant,
  input  logic        in_nan,
  input  logic        in_inf,
  input  logic        in_zero,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_overflow,
  output logic        out_underflow,
  output logic        out_inexact
);
  localparam logic signed [E_W-1:0] E_MAX = E_W'(EXP_MAX);

  logic                  s1_valid, s1_sign, s1_g, s1_s, s1_nan, s1_inf, s1_zero;
  logic [FRAC_W:0]       s1_m;
  logic signed [E_W-1:0] s1_e;
  logic                  s2_valid, s2_ready;

  logic [FRAC_W:0]       n_m;
  logic                  n_g, n_s;
  logic signed [E_W-1:0] n_e, e_in;

  logic [FRAC_W-1:0]     r_fr;
  logic signed [E_W-1:0] r_e;
  logic                  r_inexact;
  fp32_t                 p_res;
  logic                  p_ovf, p_unf, p_inx;

  assign s2_ready  = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || s2_ready;
  assign out_valid = s2_valid;

  // Hidden bit lands at n_m[23]: product is either 1x.xxx (bit 47) or 01.xxx (bit 46).
  always_comb begin
    e_in = {in_exp[9], in_exp};
    if (in_mant[47]) begin
      n_m = in_mant[47:24];
      n_g = in_mant[23];
      n_s = |in_mant[22:0];
      n_e = e_in + 11'sd1;
    end else begin
      n_m = in_mant[46:23];
      n_g = in_mant[22];
      n_s = |in_mant[21:0];
      n_e = e_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_m     <= '0;
      s1_g     <= 1'b0;
      s1_s     <= 1'b0;
      s1_e     <= '0;
      s1_nan   <= 1'b0;
      s1_inf   <= 1'b0;
      s1_zero  <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign <= in_sign;
        s1_m    <= n_m;
        s1_g    <= n_g;
        s1_s    <= n_s;
        s1_e    <= n_e;
        s1_nan  <= in_nan;
        s1_inf  <= in_inf;
        s1_zero <= in_zero;
      end
    end
  end

  fp_round_rne u_round (
    .m       (s1_m),
    .g       (s1_g),
    .s       (s1_s),
    .e       (s1_e),
    .fr      (r_fr),
    .e_out   (r_e),
    .inexact (r_inexact)
  );

  always_comb begin
    p_res      = '0;
    p_res.sign = s1_sign;
    p_ovf      = 1'b0;
    p_unf      = 1'b0;
    p_inx      = 1'b0;
    if (s1_nan) begin
      p_res = fp32_t'(QNAN);
    end else if (s1_inf) begin
      p_res.exp = '1;
    end else if (s1_zero) begin
      p_res.exp = '0;
    end else if (r_e >= E_MAX) begin
      p_res.exp = '1;
      p_ovf     = 1'b1;
      p_inx     = 1'b1;
    end else if (r_e <= 11'sd0) begin
      p_unf = 1'b1;
      p_inx = 1'b1;
    end else begin
      p_res.exp  = r_e[EXP_W-1:0];
      p_res.frac = r_fr;
      p_inx      = r_inexact;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid      <= 1'b0;
      out_result    <= '0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
      out_inexact   <= 1'b0;
    end else if (s2_ready) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_result    <= p_res;
        out_overflow  <= p_ovf;
        out_underflow <= p_unf;
        out_inexact   <= p_inx;
      end
    end
  end
endmodule
